csa_resolve: RTL and testbench
==============================

# csa_resolve

Sequential carry-propagate resolver that converts a 106-bit carry-save pair (sum vector, carry vector) into a single binary result. It sits directly after the 3:2 compression tree in the FMA datapath, replacing a wide single-cycle carry-propagate adder. It adds one CHUNK-bit slice per cycle behind a valid/ready handshake on both sides.

## Interface
- WIDTH, 106: width of the carry-save input vectors.
- CHUNK, 27: bits resolved per cycle. Legal range is 1..WIDTH+1.
- NCHUNK, derived: ceil((WIDTH+1)/CHUNK). This is 4 for the default values.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset. Synchronous, active-low.
- in_valid  in  1  the input pair is valid.
- in_ready  out  1  the block can accept an input pair.
- in_sum  in  WIDTH  sum vector. Bit i has weight 2^i.
- in_carry  in  WIDTH  carry vector. Bit i has weight 2^(i+1).
- out_valid  out  1  the result is valid.
- out_ready  in  1  the consumer accepts the result.
- out_result  out  WIDTH+2  exact value of in_sum + 2*in_carry.
- out_zero  out  1  out_result == 0. Meaningful only while out_valid=1.

## Operation
- **States**
  - IDLE: in_ready=1.
  - ADD: steps k = 0..NCHUNK-1.
  - DONE: out_valid=1.
- **Accept:** in_valid && in_ready at an edge.
  - Latch A = zero-extended in_sum and B = {in_carry, 1'b0}, both NCHUNK*CHUNK bits wide.
  - Clear the carry flop and the step counter.
  - Go to ADD.
- **ADD step k:**
  - Compute {c, s} = A[k-th chunk] + B[k-th chunk] + carry_flop.
  - Write s into result chunk k and store c in carry_flop.
  - Increment k.
  - After step NCHUNK-1, go to DONE.
  - in_ready=0 throughout ADD.
- **DONE:**
  - out_result is the lower WIDTH+2 bits of the assembled result.
  - The final carry_flop and any padding bits above WIDTH+2 are discarded; they are provably zero for legal CHUNK.
  - out_zero is the NOR of out_result.
  - Hold out_valid, out_result and out_zero stable until out_valid && out_ready, then go to IDLE.
- in_valid outside IDLE is ignored. The input vectors are not sampled except at accept.
- No bypass:
  - A handshake completing in DONE does not allow a same-cycle accept.
  - in_ready rises the cycle after DONE exits.
- **Reset** (rst_n=0 at an edge, in any state including mid-ADD or DONE):
  - Next state is IDLE and out_valid=0.
  - out_result=0, out_zero=0, carry_flop=0, step counter=0.
  - Any in-flight operation is dropped silently and no result is emitted.
- in_ready is gated to 0 while rst_n=0.

## Timing
- Reset values of outputs:
  - in_ready=0 while rst_n=0, then 1 from the first cycle after release.
  - out_valid=0, out_result=0, out_zero=0.
- Latency: accept at edge T; out_valid is first high after edge T+NCHUNK, which is 4 cycles with defaults.
- Maximum throughput: one result per NCHUNK+2 cycles, which is 6 with defaults, when out_ready is held at 1.
- out_ready may be held low indefinitely. The block stalls in DONE with all outputs stable.
- All outputs are registered or decoded from registered state. There is no combinational path from in_* or out_ready to any output.

## Test plan
- **Zero input:** in_sum=0, in_carry=0 -> out_result=0 and out_zero=1; out_valid rises exactly 4 cycles after accept.
- **Small values:** in_sum=1, in_carry=1 -> out_result=3, out_zero=0. Then in_sum=5, in_carry=2 -> out_result=9.
- **All ones:** in_sum = in_carry = all ones -> out_result = 2^107 + 2^106 - 3; checks the top bit and the discarded padding.
- **Chunk-boundary carry:** in_sum=2^27-2, in_carry=1 -> out_result=2^27. The carry must cross from chunk 0 into chunk 1. Repeat at the boundaries at bits 54 and 81.
- **Backpressure:** hold out_ready=0 for 10 cycles in DONE while pulsing in_valid with new data.
  - out_valid, out_result and out_zero stay constant; in_ready stays 0.
  - The new data is not captured.
  - After out_ready=1, in_ready rises one cycle later.
- **Reset mid-operation:** drive rst_n=0 for one edge during ADD step 2.
  - Next cycle: out_valid=0, out_result=0, state IDLE; no result is ever emitted for that input.
  - A following accept of sum=7, carry=3 gives 13 with nominal latency.

Source files
------------

// File: rtl/csa_resolve.sv
// Sequential carry-propagate resolver: turns a carry-save (sum, carry) pair into
// one binary value, adding one CHUNK-bit slice per cycle.
module csa_resolve #(
  parameter int WIDTH = 106,
  parameter int CHUNK = 27
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_sum,
  input  logic [WIDTH-1:0]   in_carry,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH+1:0]   out_result,
  output logic               out_zero,
  output logic [1:0]         dbg_state
);

  localparam int NCHUNK = (WIDTH + CHUNK) / CHUNK;
  localparam int PW     = NCHUNK * CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  // Encoding is visible on dbg_state: 0 = IDLE, 1 = ADD, 2 = DONE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   step_q, step_d;
  logic            carry_q, carry_d;
  logic [PW-1:0]   a_q, a_d;
  logic [PW-1:0]   b_q, b_d;
  logic [PW-1:0]   res_q, res_d;
  logic [CHUNK:0]  slice_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1. Input is taken only in IDLE; the result is held in DONE until taken,
  // and the handshake cycle never doubles as an accept.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    slice_sum = {1'b0, a_q[step_q*CHUNK +: CHUNK]}
              + {1'b0, b_q[step_q*CHUNK +: CHUNK]}
              + (CHUNK+1)'(carry_q);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = PW'(in_sum);
          b_d     = PW'({in_carry, 1'b0});
          carry_d = 1'b0;
          step_d  = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        res_d[step_q*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
        carry_d = slice_sum[CHUNK];
        step_d  = step_q + CW'(1);
        if (step_q == CW'(NCHUNK - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // When the slices exactly cover WIDTH+1 bits, the top result bit is the final carry.
  if (PW >= WIDTH + 2) begin : g_res_wide
    assign out_result = res_q[WIDTH+1:0];
  end else begin : g_res_tight
    assign out_result = {carry_q, res_q};
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_zero  = (state_q == DONE) && ~|out_result;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_csa_resolve.sv
// Bench for csa_resolve: directed corner cases plus randomized streams checked
// against an arithmetic reference (sum + 2*carry).
module tb_csa_resolve;

  localparam int W  = 106;
  localparam int RW = W + 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_sum;
  logic [W-1:0]  in_carry;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_result;
  logic          out_zero;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_mis = 0;
  logic [RW-1:0] exp_q[$];

  csa_resolve dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] ref_add(input logic [W-1:0] s, input logic [W-1:0] c);
    return RW'(s) + (RW'(c) << 1);
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  // driver: one full transaction from IDLE, consumer takes the result once valid
  task automatic do_op(input logic [W-1:0] s, input logic [W-1:0] c,
                       output logic [RW-1:0] res, output logic z,
                       output int lat, output logic rdy);
    rdy       = in_ready;
    in_sum    = s;
    in_carry  = c;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sum   = rand_vec();
    in_carry = rand_vec();
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_result;
    z   = out_zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_sum = '0; in_carry = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (out_result !== '0) begin n_mis++; $display("FAIL reset_out_result got=%h want=0", out_result); end
    n_cmp++; if (out_zero !== 1'b0) begin n_mis++; $display("FAIL reset_out_zero got=%b want=0", out_zero); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_mis++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_zero();
    logic [RW-1:0] res; logic z, rdy; int lat;
    do_op('0, '0, res, z, lat, rdy);
    n_cmp++; if (rdy !== 1'b1) begin n_mis++; $display("FAIL zero_ready got=%b want=1", rdy); end
    n_cmp++; if (res !== '0) begin n_mis++; $display("FAIL zero_result got=%h want=0", res); end
    n_cmp++; if (z !== 1'b1) begin n_mis++; $display("FAIL zero_flag got=%b want=1", z); end
    n_cmp++; if (lat !== 4) begin n_mis++; $display("FAIL zero_latency got=%0d want=4", lat); end
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_mis++; $display("FAIL zero_after_hs got=v%b r%b want=v0 r1", out_valid, in_ready);
    end
  endtask

  task automatic test_small();
    logic [RW-1:0] res; logic z, rdy; int lat;
    do_op(W'(1), W'(1), res, z, lat, rdy);
    n_cmp++; if (res !== RW'(3)) begin n_mis++; $display("FAIL small_1_1 got=%0d want=3", res); end
    n_cmp++; if (z !== 1'b0) begin n_mis++; $display("FAIL small_zero got=%b want=0", z); end
    do_op(W'(5), W'(2), res, z, lat, rdy);
    n_cmp++; if (res !== RW'(9)) begin n_mis++; $display("FAIL small_5_2 got=%0d want=9", res); end
  endtask

  task automatic test_all_ones();
    logic [RW-1:0] res, want; logic z, rdy; int lat;
    logic [W-1:0] ones;
    ones = '1;
    want = (RW'(1) << 107) + (RW'(1) << 106) - RW'(3);
    do_op(ones, ones, res, z, lat, rdy);
    n_cmp++; if (res !== want) begin n_mis++; $display("FAIL all_ones got=%h want=%h", res, want); end
    n_cmp++; if (z !== 1'b0) begin n_mis++; $display("FAIL all_ones_zero got=%b want=0", z); end
  endtask

  task automatic test_chunk_boundary();
    logic [RW-1:0] res, want; logic z, rdy; int lat;
    logic [W-1:0] s;
    int bnd[3] = '{27, 54, 81};
    foreach (bnd[i]) begin
      s    = (W'(1) << bnd[i]) - W'(2);
      want = RW'(1) << bnd[i];
      do_op(s, W'(1), res, z, lat, rdy);
      n_cmp++; if (res !== want) begin n_mis++; $display("FAIL boundary_%0d got=%h want=%h", bnd[i], res, want); end
    end
  endtask

  task automatic test_random_single();
    logic [RW-1:0] res, want; logic z, rdy; int lat;
    logic [W-1:0] s, c;
    for (int i = 0; i < 20; i++) begin
      s = rand_vec(); c = rand_vec();
      if (i == 0) c = '0;
      want = ref_add(s, c);
      do_op(s, c, res, z, lat, rdy);
      n_cmp++; if (res !== want || z !== (want == '0)) begin
        n_mis++; $display("FAIL random_%0d got=%h/%b want=%h/%b", i, res, z, want, want == '0);
      end
      n_cmp++; if (lat !== 4) begin n_mis++; $display("FAIL random_lat_%0d got=%0d want=4", i, lat); end
    end
  endtask

  // stream with scoreboard; fixed mode checks one result per 6 cycles
  task automatic run_stream(input int n, input bit random_mode, input string name);
    int sent, got, cyc, last_out;
    bit acc, hs, hold;
    logic [RW-1:0] hold_res, want;
    sent = 0; got = 0; cyc = 0; last_out = -1; hold = 1'b0; hold_res = '0;
    exp_q.delete();
    while (got < n && cyc < 3000) begin
      if (sent < n && (!random_mode || $urandom_range(0, 1) == 1)) begin
        in_sum = rand_vec(); in_carry = rand_vec(); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = random_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hold) begin
        n_cmp++; if (out_valid !== 1'b1 || out_result !== hold_res) begin
          n_mis++; $display("FAIL %s_stall got=v%b %h want=v1 %h", name, out_valid, out_result, hold_res);
        end
      end
      hold = out_valid && !out_ready;
      hold_res = out_result;
      if (hs) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : ~out_result;
        n_cmp++; if (out_result !== want) begin n_mis++; $display("FAIL %s_result got=%h want=%h", name, out_result, want); end
        if (!random_mode && last_out >= 0) begin
          n_cmp++; if (cyc - last_out !== 6) begin n_mis++; $display("FAIL %s_period got=%0d want=6", name, cyc - last_out); end
        end
        last_out = cyc;
        got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin exp_q.push_back(ref_add(in_sum, in_carry)); sent++; end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (got !== n) begin n_mis++; $display("FAIL %s_count got=%0d want=%0d", name, got, n); end
  endtask

  task automatic test_back_to_back();
    run_stream(5, 1'b0, "b2b");
  endtask

  task automatic test_random_stream();
    run_stream(25, 1'b1, "rstream");
  endtask

  task automatic test_backpressure();
    logic [W-1:0] s, c;
    logic [RW-1:0] want, r0; logic z0; int lat;
    s = rand_vec(); c = rand_vec();
    want = ref_add(s, c);
    in_sum = s; in_carry = c; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (out_result !== want) begin n_mis++; $display("FAIL bp_result got=%h want=%h", out_result, want); end
    r0 = out_result; z0 = out_zero;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      in_sum = rand_vec(); in_carry = rand_vec();
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || out_result !== r0 || out_zero !== z0 || in_ready !== 1'b0) begin
        n_mis++; $display("FAIL bp_hold_%0d got=v%b r%b %h z%b want=v1 r0 %h z%b",
                          i, out_valid, in_ready, out_result, out_zero, r0, z0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL bp_ready_before got=%b want=0", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_mis++; $display("FAIL bp_release got=r%b v%b want=r1 v0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [RW-1:0] res; logic z, rdy; int lat; bit seen;
    in_sum = rand_vec(); in_carry = rand_vec(); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || out_result !== '0 || dbg_state !== 2'd0 || in_ready !== 1'b0) begin
      n_mis++; $display("FAIL midreset got=v%b %h s%0d r%b want=v0 0 s0 r0", out_valid, out_result, dbg_state, in_ready);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    n_cmp++; if (seen !== 1'b0) begin n_mis++; $display("FAIL midreset_ghost got=%b want=0", seen); end
    do_op(W'(7), W'(3), res, z, lat, rdy);
    n_cmp++; if (res !== RW'(13) || lat !== 4) begin
      n_mis++; $display("FAIL midreset_next got=%0d lat=%0d want=13 lat=4", res, lat);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_small();
    test_all_ones();
    test_chunk_boundary();
    test_random_single();
    test_back_to_back();
    test_backpressure();
    test_random_stream();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
